result_checker: RTL and testbench



---
 rtl/result_checker.sv | 114 +++++++++++
 tb/tb_result_checker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/result_checker.sv
// Sequences a DUT through reset and N_CHECKS result compares against a writable expected table.
// Optional FIRST_FAIL_CAPTURE_EN adds fail_seen/fail_idx/fail_got first-mismatch capture.
module result_checker #(
    parameter int N_CHECKS   = 29,
    parameter int RST_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] result,
    input  logic        exp_we,
    input  logic [4:0]  exp_addr,
    input  logic [31:0] exp_data,
    output logic        dut_reset,
    output logic        busy,
    output logic        done,
    output logic [5:0]  score,
    output logic        pass_all
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    output logic        fail_seen,
    output logic [4:0]  fail_idx,
    output logic [31:0] fail_got
`endif
);

    // state     | meaning
    // IDLE      | DUT held in reset, table writable
    // RESET_DUT | DUT reset asserted for RST_CYCLES cycles
    // CHECK     | one compare per cycle, idx 0..N_CHECKS-1
    // DONE      | score/pass_all held, table writable
    typedef enum logic [1:0] {S_IDLE, S_RESET_DUT, S_CHECK, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  rst_cnt;
    logic [4:0]  idx;
    logic [31:0] exp_mem [N_CHECKS];
    logic [31:0] exp_cur;
    logic        idle_or_done, launch, tbl_wr, last_rst, last_idx, hit;

    always_comb begin
        idle_or_done = (state == S_IDLE) || (state == S_DONE);
        launch       = idle_or_done && start;
        tbl_wr       = idle_or_done && exp_we && ({1'b0, exp_addr} < 6'(N_CHECKS));
        last_rst     = (rst_cnt == 4'(RST_CYCLES - 1));
        last_idx     = (idx == 5'(N_CHECKS - 1));
        // Constant-index mux keeps the read free of index-width issues for small N_CHECKS.
        exp_cur = '0;
        for (int i = 0; i < N_CHECKS; i++) begin
            if (idx == 5'(i)) exp_cur = exp_mem[i];
        end
        hit = (result == exp_cur);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: if (start)    state_nxt = S_RESET_DUT;
            S_RESET_DUT:    if (last_rst) state_nxt = S_CHECK;
            S_CHECK:        if (last_idx) state_nxt = S_DONE;
            default:                      state_nxt = S_IDLE;
        endcase
        dut_reset = (state == S_IDLE) || (state == S_RESET_DUT);
        busy      = (state == S_RESET_DUT) || (state == S_CHECK);
        done      = (state == S_DONE);
        pass_all  = (state == S_DONE) && (score == 6'(N_CHECKS));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            rst_cnt <= '0;
            idx     <= '0;
            score   <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
            fail_seen <= 1'b0;
            fail_idx  <= '0;
            fail_got  <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (launch) begin
                rst_cnt <= '0;
                idx     <= '0;
                score   <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
                fail_seen <= 1'b0;
                fail_idx  <= '0;
                fail_got  <= '0;
`endif
            end
            if (state == S_RESET_DUT) rst_cnt <= rst_cnt + 4'd1;
            if (state == S_CHECK) begin
                idx <= idx + 5'd1;
                if (hit) score <= score + 6'd1;
`ifdef FIRST_FAIL_CAPTURE_EN
                if (!hit && !fail_seen) begin
                    fail_seen <= 1'b1;
                    fail_idx  <= idx;
                    fail_got  <= result;
                end
`endif
            end
        end
    end

    // Table survives reset and start so a test vector set can be reused across runs.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CHECKS; i++) begin
            if (tbl_wr && (exp_addr == 5'(i))) exp_mem[i] <= exp_data;
        end
    end

endmodule

// File: tb/tb_result_checker.sv
// Randomized self-checking bench for result_checker: default instance plus an N_CHECKS=1, RST_CYCLES=3 instance.
module tb_result_checker;

    localparam int N  = 29;
    localparam int RC = 1;

    logic        clk = 1'b0;
    logic        reset, start, exp_we;
    logic [31:0] result, exp_data;
    logic [4:0]  exp_addr;
    logic        dut_reset, busy, done, pass_all;
    logic [5:0]  score;

    logic        s_start, s_we;
    logic [31:0] s_result, s_data;
    logic [4:0]  s_addr;
    logic        s_dut_reset, s_busy, s_done, s_pass;
    logic [5:0]  s_score;

`ifdef FIRST_FAIL_CAPTURE_EN
    logic        fail_seen, s_fail_seen;
    logic [4:0]  fail_idx, s_fail_idx;
    logic [31:0] fail_got, s_fail_got;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_ref [32];
    logic [31:0] res_seq [32];

    always #5 clk = ~clk;

    result_checker #(.N_CHECKS(N), .RST_CYCLES(RC)) u_dut (
        .clk(clk), .reset(reset), .start(start), .result(result),
        .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
        .dut_reset(dut_reset), .busy(busy), .done(done), .score(score), .pass_all(pass_all)
`ifdef FIRST_FAIL_CAPTURE_EN
        , .fail_seen(fail_seen), .fail_idx(fail_idx), .fail_got(fail_got)
`endif
    );

    result_checker #(.N_CHECKS(1), .RST_CYCLES(3)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .result(s_result),
        .exp_we(s_we), .exp_addr(s_addr), .exp_data(s_data),
        .dut_reset(s_dut_reset), .busy(s_busy), .done(s_done), .score(s_score), .pass_all(s_pass)
`ifdef FIRST_FAIL_CAPTURE_EN
        , .fail_seen(s_fail_seen), .fail_idx(s_fail_idx), .fail_got(s_fail_got)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full run on the default instance; res_seq holds the per-entry result values.
    task automatic run(input string tag, input bit wr_start, input logic [4:0] wa,
                       input logic [31:0] wd, input bit disturb);
        int hi, exp_score, first_bad;
        if (wr_start) begin
            exp_we = 1'b1; exp_addr = wa; exp_data = wd;
            if (wa < 5'(N)) exp_ref[wa] = wd;
        end
        start = 1'b1;
        tick();
        start = 1'b0; exp_we = 1'b0;
        chk({tag, ".score_clr"}, 64'(score), 64'd0);
        hi = 0;
        while (dut_reset === 1'b1 && hi < 20) begin
            hi++;
            tick();
        end
        chk({tag, ".rst_len"}, 64'(hi), 64'(RC));
        exp_score = 0;
        first_bad = -1;
        for (int k = 0; k < N; k++) begin
            result = res_seq[k];
            if (disturb && k == 3) begin
                exp_we = 1'b1; exp_addr = 5'd3; exp_data = 32'hdeadbeef; start = 1'b1;
            end
            tick();
            exp_we = 1'b0; start = 1'b0;
            if (res_seq[k] == exp_ref[k]) exp_score++;
            else if (first_bad < 0) first_bad = k;
            if (k == N - 2) chk({tag, ".busy_pre"}, {63'd0, busy, done}, 64'd2);
        end
        chk({tag, ".done"}, {62'd0, done, busy}, 64'd2);
        chk({tag, ".score"}, 64'(score), 64'(exp_score));
        chk({tag, ".pass_all"}, 64'(pass_all), 64'(exp_score == N));
`ifdef FIRST_FAIL_CAPTURE_EN
        chk({tag, ".fail_seen"}, 64'(fail_seen), 64'(first_bad >= 0));
        if (first_bad >= 0) begin
            chk({tag, ".fail_idx"}, 64'(fail_idx), 64'(first_bad));
            chk({tag, ".fail_got"}, 64'(fail_got), 64'(res_seq[first_bad]));
        end
`endif
        result = $urandom;
        tick();
        tick();
        chk({tag, ".hold"}, {57'd0, done, score}, {57'd1, 6'(exp_score)});
    endtask

    task automatic small_run(input string tag, input logic [31:0] r, input int exp_sc);
        int hi;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk({tag, ".score_clr"}, 64'(s_score), 64'd0);
        hi = 0;
        while (s_dut_reset === 1'b1 && hi < 20) begin
            hi++;
            tick();
        end
        chk({tag, ".rst_len"}, 64'(hi), 64'd3);
        s_result = r;
        tick();
        chk({tag, ".done"}, {62'd0, s_done, s_busy}, 64'd2);
        chk({tag, ".score"}, 64'(s_score), 64'(exp_sc));
        chk({tag, ".pass"}, 64'(s_pass), 64'(exp_sc == 1));
    endtask

    initial begin
        logic [31:0] v;
        int hi;
        reset = 1'b1; start = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_data = '0; result = '0;
        s_start = 1'b0; s_we = 1'b0; s_addr = '0; s_data = '0; s_result = '0;
        tick();
        tick();
        chk("reset.main", {59'd0, dut_reset, busy, done, pass_all, (score == 6'd0)}, 64'b10001);
        chk("reset.small", {59'd0, s_dut_reset, s_busy, s_done, s_pass, (s_score == 6'd0)}, 64'b10001);
        reset = 1'b0;
        tick();
        chk("idle.dut_reset", 64'(dut_reset), 64'd1);

        for (int i = 0; i < N; i++) begin
            exp_ref[i] = $urandom;
            exp_we = 1'b1; exp_addr = 5'(i); exp_data = exp_ref[i];
            tick();
        end
        exp_we = 1'b1; exp_addr = 5'd31; exp_data = $urandom;
        tick();
        exp_we = 1'b0;

        for (int k = 0; k < N; k++) res_seq[k] = exp_ref[k];
        run("all_match", 1'b0, 5'd0, 32'd0, 1'b0);

        for (int k = 0; k < N; k++) res_seq[k] = exp_ref[k];
        res_seq[9] = 32'h0;
        run("entry9", 1'b1, 5'd9, 32'hfffffffe, 1'b0);

        for (int k = 0; k < N; k++) res_seq[k] = exp_ref[k];
        run("busy_write", 1'b0, 5'd0, 32'd0, 1'b1);
        run("after_busy_write", 1'b0, 5'd0, 32'd0, 1'b0);

        v = $urandom;
        for (int k = 0; k < N; k++) res_seq[k] = exp_ref[k];
        res_seq[0] = v;
        run("start_and_write", 1'b1, 5'd0, v, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++)
                res_seq[k] = ($urandom_range(0, 3) == 0) ? $urandom : exp_ref[k];
            run($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                $urandom, 1'b0);
        end

        start = 1'b1;
        tick();
        start = 1'b0;
        hi = 0;
        while (dut_reset === 1'b1 && hi < 20) begin
            hi++;
            tick();
        end
        chk("abort.rst_len", 64'(hi), 64'(RC));
        for (int k = 0; k < 10; k++) begin
            result = exp_ref[k];
            if (k == 5) start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk("abort.pre_score", {57'd0, busy, score}, {57'd1, 6'd10});
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        chk("abort.state", {58'd0, dut_reset, busy, done, pass_all, score == 6'd0, 1'b0}, 64'b100010);
        tick();
        chk("abort.idle_hold", {62'd0, dut_reset, busy}, 64'b10);

        for (int k = 0; k < N; k++) res_seq[k] = exp_ref[k];
        run("post_abort", 1'b0, 5'd0, 32'd0, 1'b0);

        v = $urandom;
        s_we = 1'b1; s_addr = 5'd0; s_data = v;
        tick();
        s_addr = 5'd1; s_data = ~v;
        tick();
        s_we = 1'b0;
        small_run("small1", v, 1);
        small_run("small2", v ^ 32'h1, 0);
        small_run("small3", v, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
